code_lock: RTL and testbench

Parametrised sequential code lock for the keypad path. It accepts one digit per `key_valid` strobe and compares a CODE_LEN-digit entry against a programmable code register. It drives `locked`, counts failed attempts, and enters a timed lockout after MAX_FAILS consecutive wrong codes. While unlocked, the code can be reprogrammed.

---
 rtl/code_lock.sv | 147 ++++++++++++++
 tb/tb_code_lock.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/code_lock.sv
// Keypad code lock: digit-serial entry, failed-attempt lockout and
// in-place reprogramming of the stored code while unlocked.
module code_lock #(
  parameter int DIGIT_W        = 4,
  parameter int CODE_LEN       = 6,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 24'h335256
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              key_valid,
  input  logic [DIGIT_W-1:0]                key,
  input  logic                              relock,
  input  logic                              prog_en,
  output logic                              locked,
  output logic                              alarm,
  output logic [$clog2(MAX_FAILS+1)-1:0]    fail_count,
  output logic [$clog2(CODE_LEN+1)-1:0]     digit_count
);

  localparam int CW = CODE_LEN * DIGIT_W;
  localparam int PW = CW - DIGIT_W;
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int DW = $clog2(CODE_LEN + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [DIGIT_W-1:0] CLEAR = '1;
  localparam logic [DW-1:0]      LAST  = DW'(CODE_LEN - 1);
  localparam logic [FW-1:0]      FMAX  = FW'(MAX_FAILS);
  localparam logic [LW-1:0]      LTOP  = LW'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_ENTRY,
    S_UNLOCKED,
    S_PROGRAM,
    S_LOCKOUT
  } state_t;

  state_t          state;
  logic [CW-1:0]   code_q;
  logic [PW-1:0]   entry_q;
  logic [PW-1:0]   shadow_q;
  logic [LW-1:0]   lock_cnt;

  logic            is_clear;
  logic            last;
  logic            match;
  logic [CW-1:0]   entry_word;
  logic [CW-1:0]   shadow_word;
  logic [FW-1:0]   fail_nxt;

  // The final digit is folded in combinationally so the whole code is
  // judged on the same edge that samples it.
  always_comb begin
    is_clear    = (key == CLEAR);
    last        = (digit_count == LAST);
    entry_word  = {entry_q, key};
    shadow_word = {shadow_q, key};
    match       = (entry_word == code_q);
    fail_nxt    = (fail_count == FMAX) ? FMAX : fail_count + FW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_ENTRY;
      locked      <= 1'b1;
      alarm       <= 1'b0;
      fail_count  <= '0;
      digit_count <= '0;
      code_q      <= DEFAULT_CODE;
      entry_q     <= '0;
      shadow_q    <= '0;
      lock_cnt    <= '0;
    end else begin
      unique case (state)
        S_LOCKOUT: begin
          if (lock_cnt == '0) begin
            state      <= S_ENTRY;
            alarm      <= 1'b0;
            fail_count <= '0;
          end else begin
            lock_cnt <= lock_cnt - LW'(1);
          end
        end
        S_ENTRY: begin
          if (relock) begin
            digit_count <= '0;
          end else if (key_valid) begin
            if (is_clear) begin
              digit_count <= '0;
            end else if (last) begin
              digit_count <= '0;
              if (match) begin
                state      <= S_UNLOCKED;
                locked     <= 1'b0;
                fail_count <= '0;
              end else begin
                fail_count <= fail_nxt;
                if (fail_nxt == FMAX) begin
                  state    <= S_LOCKOUT;
                  alarm    <= 1'b1;
                  lock_cnt <= LTOP;
                end
              end
            end else begin
              entry_q     <= entry_word[PW-1:0];
              digit_count <= digit_count + DW'(1);
            end
          end
        end
        S_UNLOCKED: begin
          if (relock) begin
            state       <= S_ENTRY;
            locked      <= 1'b1;
            digit_count <= '0;
          end else if (key_valid && prog_en && !is_clear) begin
            state       <= S_PROGRAM;
            shadow_q    <= shadow_word[PW-1:0];
            digit_count <= DW'(1);
          end
        end
        S_PROGRAM: begin
          if (relock) begin
            state       <= S_ENTRY;
            locked      <= 1'b1;
            digit_count <= '0;
          end else if (!prog_en || (key_valid && is_clear)) begin
            state       <= S_UNLOCKED;
            digit_count <= '0;
          end else if (key_valid) begin
            if (last) begin
              code_q      <= shadow_word;
              state       <= S_UNLOCKED;
              digit_count <= '0;
            end else begin
              shadow_q    <= shadow_word[PW-1:0];
              digit_count <= digit_count + DW'(1);
            end
          end
        end
        default: state <= S_ENTRY;
      endcase
    end
  end

endmodule

// File: tb/tb_code_lock.sv
// Scoreboard bench for code_lock: expected {locked,alarm,fail,digits}
// per cycle queued with the stimulus, compared against captured outputs.
module tb_code_lock;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key = 4'h0;
  logic       relock = 1'b0;
  logic       prog_en = 1'b0;
  logic       locked;
  logic       alarm;
  logic [1:0] fail_count;
  logic [2:0] digit_count;

  code_lock dut (
    .clk(clk),
    .reset(reset),
    .key_valid(key_valid),
    .key(key),
    .relock(relock),
    .prog_en(prog_en),
    .locked(locked),
    .alarm(alarm),
    .fail_count(fail_count),
    .digit_count(digit_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [6:0] v;
  } exp_t;

  exp_t       exp_q[$];
  logic [6:0] got_q[$];
  int         n_run = 0;
  int         n_fail = 0;

  wire [6:0] obs = {locked, alarm, fail_count, digit_count};

  localparam logic [23:0] DEF  = 24'h335256;
  localparam logic [23:0] BAD  = 24'h335257;
  localparam logic [23:0] NEWC = 24'h123456;

  function automatic logic [6:0] ex(input logic l, input logic a,
                                    input logic [1:0] f,
                                    input logic [2:0] d);
    return {l, a, f, d};
  endfunction

  task automatic step(input logic rst, input logic kv,
                      input logic [3:0] k, input logic pe,
                      input logic rl, input logic [6:0] e,
                      input string nm);
    reset     = rst;
    key_valid = kv;
    key       = k;
    prog_en   = pe;
    relock    = rl;
    exp_q.push_back('{name: nm, v: e});
    @(posedge clk);
    #1;
    got_q.push_back(obs);
    reset     = 1'b0;
    key_valid = 1'b0;
    relock    = 1'b0;
  endtask

  task automatic idle(input logic pe, input logic [6:0] e,
                      input string nm);
    step(1'b0, 1'b0, 4'h0, pe, 1'b0, e, nm);
  endtask

  // Six locked-entry digits; fb is the fail count held during entry.
  task automatic enter(input logic [23:0] c, input logic [1:0] fb,
                       input logic [6:0] fin, input string nm);
    logic [6:0] e;
    for (int i = 0; i < 6; i++) begin
      e = (i == 5) ? fin : ex(1'b1, 1'b0, fb, 3'(i + 1));
      step(1'b0, 1'b1, c[23-4*i -: 4], 1'b0, 1'b0, e,
           $sformatf("%s_d%0d", nm, i));
    end
  endtask

  task automatic test_reset;
    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, ex(1, 0, 0, 0), "reset0");
    step(1'b1, 1'b1, 4'h3, 1'b1, 1'b1, ex(1, 0, 0, 0), "reset_keys");
    idle(1'b0, ex(1, 0, 0, 0), "reset_idle");
    while (exp_q.size() != 0) begin
      exp_t e;
      logic [6:0] g;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_run++;
      if (g !== e.v) begin
        n_fail++;
        $display("FAIL %s: got {l,a,f,d}=%b required %b", e.name, g, e.v);
      end
    end
  endtask

  task automatic test_unlock;
    enter(DEF, 2'd0, ex(0, 0, 0, 0), "unlock");
    idle(1'b0, ex(0, 0, 0, 0), "unlock_hold");
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, ex(1, 0, 0, 0), "relock");
    while (exp_q.size() != 0) begin
      exp_t e;
      logic [6:0] g;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_run++;
      if (g !== e.v) begin
        n_fail++;
        $display("FAIL %s: got {l,a,f,d}=%b required %b", e.name, g, e.v);
      end
    end
  endtask

  task automatic test_lockout;
    logic [6:0] e;
    enter(BAD, 2'd0, ex(1, 0, 1, 0), "fail1");
    enter(BAD, 2'd1, ex(1, 0, 2, 0), "fail2");
    enter(BAD, 2'd2, ex(1, 1, 3, 0), "fail3");
    for (int i = 0; i < 16; i++) begin
      e = (i < 15) ? ex(1, 1, 3, 0) : ex(1, 0, 0, 0);
      step(1'b0, 1'b1, 4'h3, i[0], i[1], e, $sformatf("lockout_%0d", i));
    end
    enter(DEF, 2'd0, ex(0, 0, 0, 0), "post_lockout");
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, ex(1, 0, 0, 0), "relock_lo");
    while (exp_q.size() != 0) begin
      exp_t x;
      logic [6:0] g;
      x = exp_q.pop_front();
      g = got_q.pop_front();
      n_run++;
      if (g !== x.v) begin
        n_fail++;
        $display("FAIL %s: got {l,a,f,d}=%b required %b", x.name, g, x.v);
      end
    end
  endtask

  task automatic test_clear;
    step(1'b0, 1'b1, 4'h3, 1'b0, 1'b0, ex(1, 0, 0, 1), "clr_d0");
    step(1'b0, 1'b1, 4'h3, 1'b0, 1'b0, ex(1, 0, 0, 2), "clr_d1");
    step(1'b0, 1'b1, 4'hf, 1'b0, 1'b0, ex(1, 0, 0, 0), "clear");
    enter(DEF, 2'd0, ex(0, 0, 0, 0), "clr_unlock");
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, ex(1, 0, 0, 0), "relock_clr");
    while (exp_q.size() != 0) begin
      exp_t e;
      logic [6:0] g;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_run++;
      if (g !== e.v) begin
        n_fail++;
        $display("FAIL %s: got {l,a,f,d}=%b required %b", e.name, g, e.v);
      end
    end
  endtask

  task automatic test_relock_drop;
    enter(DEF, 2'd0, ex(0, 0, 0, 0), "rd_unlock");
    step(1'b0, 1'b1, 4'h9, 1'b1, 1'b0, ex(0, 0, 0, 1), "rd_p0");
    step(1'b0, 1'b1, 4'h9, 1'b1, 1'b0, ex(0, 0, 0, 2), "rd_p1");
    step(1'b0, 1'b1, 4'h9, 1'b1, 1'b0, ex(0, 0, 0, 3), "rd_p2");
    step(1'b0, 1'b1, 4'h9, 1'b1, 1'b1, ex(1, 0, 0, 0), "rd_relock");
    enter(DEF, 2'd0, ex(0, 0, 0, 0), "rd_old_ok");
    // prog_en falling mid-sequence aborts back to unlocked
    step(1'b0, 1'b1, 4'h4, 1'b1, 1'b0, ex(0, 0, 0, 1), "ab_p0");
    idle(1'b0, ex(0, 0, 0, 0), "ab_drop");
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, ex(1, 0, 0, 0), "ab_relock");
    enter(DEF, 2'd0, ex(0, 0, 0, 0), "ab_old_ok");
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, ex(1, 0, 0, 0), "ab_relock2");
    while (exp_q.size() != 0) begin
      exp_t e;
      logic [6:0] g;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_run++;
      if (g !== e.v) begin
        n_fail++;
        $display("FAIL %s: got {l,a,f,d}=%b required %b", e.name, g, e.v);
      end
    end
  endtask

  task automatic test_program;
    logic [6:0] e;
    enter(DEF, 2'd0, ex(0, 0, 0, 0), "pg_unlock");
    for (int i = 0; i < 6; i++) begin
      e = ex(0, 0, 0, 3'((i + 1) % 6));
      step(1'b0, 1'b1, NEWC[23-4*i -: 4], 1'b1, 1'b0, e,
           $sformatf("pg_p%0d", i));
    end
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, ex(1, 0, 0, 0), "pg_relock");
    enter(DEF, 2'd0, ex(1, 0, 1, 0), "pg_old_fails");
    enter(NEWC, 2'd1, ex(0, 0, 0, 0), "pg_new_ok");
    while (exp_q.size() != 0) begin
      exp_t x;
      logic [6:0] g;
      x = exp_q.pop_front();
      g = got_q.pop_front();
      n_run++;
      if (g !== x.v) begin
        n_fail++;
        $display("FAIL %s: got {l,a,f,d}=%b required %b", x.name, g, x.v);
      end
    end
  endtask

  task automatic test_reset_mid_program;
    step(1'b0, 1'b1, 4'h7, 1'b1, 1'b0, ex(0, 0, 0, 1), "rm_p0");
    step(1'b0, 1'b1, 4'h7, 1'b1, 1'b0, ex(0, 0, 0, 2), "rm_p1");
    step(1'b1, 1'b1, 4'h7, 1'b1, 1'b0, ex(1, 0, 0, 0), "rm_reset");
    enter(NEWC, 2'd0, ex(1, 0, 1, 0), "rm_new_fails");
    enter(DEF, 2'd1, ex(0, 0, 0, 0), "rm_def_ok");
    while (exp_q.size() != 0) begin
      exp_t e;
      logic [6:0] g;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_run++;
      if (g !== e.v) begin
        n_fail++;
        $display("FAIL %s: got {l,a,f,d}=%b required %b", e.name, g, e.v);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_unlock();
    test_lockout();
    test_clear();
    test_relock_drop();
    test_program();
    test_reset_mid_program();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
